sinc3_decimator: RTL and testbench
==================================

Name: sinc3_decimator

Overview:
- Downstream companion to the sinc^3 sigma-delta filter. Consumes the filter's full-rate signed output and keeps every OSR-th sample.
- Discards the first samples after start-up or resynchronisation, while the filter is still settling.
- Rescales each kept sample to the system sample width with rounding and saturation.
- Buffers samples in a small FIFO behind a valid/ready interface, feeding the downstream DSP chain.

Parameters:
- OSR, 16: decimation ratio; must equal the upstream filter's OSR; power of 2, ≥4.
- OUT_W, 16: output sample width, ≥4.
- DROP, 2: decimated samples discarded after reset/sync; 0..15.
- DEPTH, 4: FIFO depth; power of 2, ≥2.
- IN_W (derived, not overridable): 3*$clog2(OSR)+1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_en  in  1  input sample strobe; the same enable that clocks the upstream filter.
- in_data  in  IN_W  signed filter output; valid in any cycle where in_en=1.
- sync  in  1  phase realignment pulse.
- out_data  out  OUT_W  signed FIFO head sample.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts the head sample.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.
- overflow  out  1  sticky: a sample was lost because the FIFO was full.
- ovf_clr  in  1  clears overflow.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - phase=0, drop_cnt=DROP, scaled register empty.
  - FIFO empty: out_valid=0, out_data=0, level=0.
  - overflow=0.
  - Reset mid-operation loses all buffered samples.
- Phase counter, 0..OSR-1:
  - Increments on in_en and wraps from OSR-1 to 0.
  - A capture occurs on an edge where in_en=1 and phase=OSR-1; in_data at that edge is the decimated sample.
  - First capture after reset is the OSR-th in_en.
- sync=1:
  - Forces phase=0 and drop_cnt=DROP at that edge. Overrides a same-edge increment and any same-edge capture (that sample is discarded).
  - FIFO and overflow are unaffected.
- Drop logic: while drop_cnt>0, each capture decrements drop_cnt and the sample is discarded. Later captures proceed to scaling.
- Scaling (capture edge → registered stage, 1 clk):
  - If OUT_W ≥ IN_W: sign-extend, then shift left by OUT_W-IN_W. Exact, no saturation.
  - If OUT_W < IN_W: let S = IN_W-OUT_W. Compute (in_data + 2^(S-1)) >>> S (round half up), with the add done at IN_W+1 bits. Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- FIFO push: the registered scaled sample is pushed on the edge after capture.
  - out_valid rises 2 clk edges after the capture edge when the FIFO was empty.
  - out_data is the head entry directly (no extra latency).
- FIFO pop: on an edge with out_valid & out_ready.
  - out_data/out_valid must stay stable while out_valid=1 and out_ready=0.
- Full FIFO (level=DEPTH):
  - Push with a simultaneous pop: accepted, level stays DEPTH.
  - Push without a pop: sample discarded, overflow set at that edge.
- ovf_clr clears overflow. If it coincides with a new overflow event, overflow ends up 1 (set wins).
- Empty FIFO with a simultaneous push and pop is impossible, since out_valid=0; the push simply lands.
- Pointers wrap modulo DEPTH. level is the exact count 0..DEPTH.
- in_en=0 freezes phase and captures. FIFO drain continues regardless of in_en.

Test Plan:
- Reset release, OSR=16, DROP=2, in_en every clock, in_data=13'sd100:
  - First two captures (the 16th and 32nd strobes) are dropped.
  - out_valid rises 2 clks after the 48th strobe with out_data=16'sd800 (shift left 3).
  - level=1.
- OUT_W=8, OSR=16 (S=5):
  - in_data=4095 → 127 (saturated).
  - in_data=-4096 → -128.
  - in_data=48 → 2.
  - in_data=-49 → -2.
- out_ready=0 with DEPTH=4, constant captures:
  - level climbs to 4.
  - 5th kept sample sets overflow=1; FIFO contents stay the first 4 samples, in order.
  - ovf_clr → overflow=0.
- Full FIFO, out_ready=1 held on the same edge as a push: level stays 4 and the new sample is accepted.
- sync pulse asserted on a capture edge:
  - That sample is discarded, and the next DROP captures are also discarded.
  - Next kept sample arrives after (DROP+1)*OSR strobes counted from the sync.
- rst_n low mid-stream with level=3 → out_valid=0 and level=0 immediately (asynchronous), overflow=0, phase restarts at 0.

Source files
------------

// File: rtl/sinc3_decimator.sv
// sinc3_decimator: keeps every OSR-th sinc^3 output, drops settling samples,
// rescales to OUT_W with rounding/saturation and buffers them in a small FIFO.
module sinc3_decimator #(
  parameter  int OSR   = 16,
  parameter  int OUT_W = 16,
  parameter  int DROP  = 2,
  parameter  int DEPTH = 4,
  localparam int IN_W  = 3*$clog2(OSR)+1,
  localparam int LW    = $clog2(DEPTH)+1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_en,
  input  logic signed [IN_W-1:0]  in_data,
  input  logic                    sync,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LW-1:0]           level,
  output logic                    overflow,
  input  logic                    ovf_clr
);

  localparam int PW = $clog2(OSR);
  localparam int AW = $clog2(DEPTH);
  localparam logic [PW-1:0] PH_LAST = PW'(OSR-1);
  localparam logic [3:0]    DROP_V  = 4'(DROP);
  localparam logic [LW-1:0] FULL_V  = LW'(DEPTH);

  logic [PW-1:0]           phase_q, phase_d;
  logic [3:0]              drop_q, drop_d;
  logic signed [IN_W-1:0]  cap_q, cap_d;
  logic                    cap_vld_q, cap_vld_d;
  logic signed [OUT_W-1:0] scl_q, scl_d, scl_val;
  logic                    scl_vld_q, scl_vld_d;
  logic [OUT_W-1:0]        mem_q [DEPTH];
  logic [OUT_W-1:0]        mem_d [DEPTH];
  logic [AW-1:0]           wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0]           lvl_q, lvl_d;
  logic                    ovf_q, ovf_d;
  logic                    hit, push, pop, full, accept;

  // Phase tracking, settling drop and decimated sample capture.
  always_comb begin
    hit       = in_en && (phase_q == PH_LAST);
    phase_d   = phase_q;
    drop_d    = drop_q;
    cap_d     = cap_q;
    cap_vld_d = 1'b0;
    if (sync) begin
      phase_d = '0;
      drop_d  = DROP_V;
    end else begin
      if (in_en) phase_d = phase_q + 1'b1;
      if (hit) begin
        if (drop_q != '0) begin
          drop_d = drop_q - 1'b1;
        end else begin
          cap_d     = in_data;
          cap_vld_d = 1'b1;
        end
      end
    end
  end

  generate
    if (OUT_W >= IN_W) begin : g_widen
      // Widening is exact: sign-extend and left-justify.
      always_comb begin
        scl_val = OUT_W'(cap_q) <<< (OUT_W-IN_W);
      end
    end else begin : g_narrow
      localparam int S = IN_W-OUT_W;
      localparam logic signed [IN_W:0] RND  = (IN_W+1)'(2**(S-1));
      localparam logic signed [IN_W:0] MAXV = (IN_W+1)'(2**(OUT_W-1)-1);
      localparam logic signed [IN_W:0] MINV = (IN_W+1)'(-(2**(OUT_W-1)));
      logic signed [IN_W:0] sum;
      logic signed [IN_W:0] sh;
      // Round half up with one guard bit, then clamp to the output range.
      always_comb begin
        sum = $signed({cap_q[IN_W-1], cap_q}) + RND;
        sh  = sum >>> S;
        if (sh > MAXV)      scl_val = MAXV[OUT_W-1:0];
        else if (sh < MINV) scl_val = MINV[OUT_W-1:0];
        else                scl_val = sh[OUT_W-1:0];
      end
    end
  endgenerate

  // Scaled sample register between capture and FIFO write.
  always_comb begin
    scl_d     = scl_q;
    scl_vld_d = cap_vld_q;
    if (cap_vld_q) scl_d = scl_val;
  end

  // Front-end state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q   <= '0;
      drop_q    <= DROP_V;
      cap_q     <= '0;
      cap_vld_q <= 1'b0;
      scl_q     <= '0;
      scl_vld_q <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      drop_q    <= drop_d;
      cap_q     <= cap_d;
      cap_vld_q <= cap_vld_d;
      scl_q     <= scl_d;
      scl_vld_q <= scl_vld_d;
    end
  end

  // FIFO next state; a full push only lands if the head leaves this edge.
  always_comb begin
    push   = scl_vld_q;
    pop    = (lvl_q != '0) && out_ready;
    full   = (lvl_q == FULL_V);
    accept = push && (!full || pop);
    mem_d  = mem_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    if (accept) begin
      mem_d[wr_q] = scl_q;
      wr_d        = wr_q + 1'b1;
    end
    if (pop) rd_d = rd_q + 1'b1;
    lvl_d = lvl_q + LW'(accept) - LW'(pop);
    ovf_d = (push && full && !pop) || (ovf_q && !ovf_clr);
  end

  // FIFO storage, pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      lvl_q <= lvl_d;
      ovf_q <= ovf_d;
    end
  end

  assign out_valid = (lvl_q != '0);
  assign out_data  = out_valid ? mem_q[rd_q] : '0;
  assign level     = lvl_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_sinc3_decimator.sv
// tb_sinc3_decimator: directed vectors, scoreboard queues per DUT,
// a negedge monitor compares every popped sample.
module tb_sinc3_decimator;

  localparam int IN_W = 13;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, in_en, sync, ovf_clr, rdy_a;
  logic signed [IN_W-1:0] in_data;
  logic signed [15:0] dat_a;
  logic vld_a, ovf_a;
  logic [2:0] lvl_a;
  logic signed [7:0] dat_b;
  logic vld_b, ovf_b;
  logic [2:0] lvl_b;

  int checks = 0;
  int errors = 0;
  int drops_left = 2;
  logic signed [15:0] q_a[$];
  logic signed [7:0]  q_b[$];

  sinc3_decimator #(.OSR(16), .OUT_W(16), .DROP(2), .DEPTH(4)) u_a (
    .clk(clk), .rst_n(rst_n), .in_en(in_en), .in_data(in_data),
    .sync(sync), .out_data(dat_a), .out_valid(vld_a),
    .out_ready(rdy_a), .level(lvl_a), .overflow(ovf_a),
    .ovf_clr(ovf_clr)
  );

  sinc3_decimator #(.OSR(16), .OUT_W(8), .DROP(2), .DEPTH(4)) u_b (
    .clk(clk), .rst_n(rst_n), .in_en(in_en), .in_data(in_data),
    .sync(sync), .out_data(dat_b), .out_valid(vld_b),
    .out_ready(1'b1), .level(lvl_b), .overflow(ovf_b),
    .ovf_clr(ovf_clr)
  );

  task automatic chk(input string nm, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One decimation period of constant input; expected values queued if kept.
  task automatic run(input int v, input int e_a, input int e_b,
                     input bit keep_a, input bit gap);
    if (drops_left > 0) begin
      drops_left--;
    end else begin
      q_b.push_back(8'(e_b));
      if (keep_a) q_a.push_back(16'(e_a));
    end
    for (int i = 0; i < 16; i++) begin
      in_data = IN_W'(v);
      in_en = 1'b1;
      tick();
      if (gap) begin
        in_en = 1'b0;
        tick();
      end
    end
  endtask

  task automatic drain;
    int n = 0;
    rdy_a = 1'b1;
    while ((lvl_a != 0 || lvl_b != 0) && n < 40) begin
      tick();
      n++;
    end
    chk("drain_level", 32'(lvl_a), 0);
  endtask

  // Scoreboard monitor: compare the head on every pop.
  initial begin
    forever begin
      @(negedge clk);
      if (vld_a && rdy_a) begin
        if (q_a.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_a unexpected got %0d want none", dat_a);
        end else begin
          chk("pop_a", dat_a, q_a.pop_front());
        end
      end
      if (vld_b) begin
        if (q_b.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_b unexpected got %0d want none", dat_b);
        end else begin
          chk("pop_b", dat_b, q_b.pop_front());
        end
      end
    end
  end

  initial begin
    rst_n = 1'b1; in_en = 1'b0; in_data = '0;
    sync = 1'b0; ovf_clr = 1'b0; rdy_a = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(vld_a), 0);
    chk("rst_level", 32'(lvl_a), 0);
    chk("rst_ovf", 32'(ovf_a), 0);
    chk("rst_data", dat_a, 0);
    chk("rst_valid_b", 32'(vld_b), 0);
    tick(); tick();
    rst_n = 1'b1;
    drops_left = 2;

    // Start-up: two dropped, third kept; latency two edges.
    run(100, 800, 3, 1, 0);
    run(100, 800, 3, 1, 0);
    run(100, 800, 3, 1, 0);
    in_en = 1'b0;
    tick();
    chk("first_valid_early", 32'(vld_a), 0);
    tick();
    chk("first_valid", 32'(vld_a), 1);
    chk("first_data", dat_a, 800);
    chk("first_level", 32'(lvl_a), 1);

    // Fill to full, then overflow on the fifth kept sample.
    run(4095, 32760, 127, 1, 0);
    run(-4096, -32768, -128, 1, 0);
    run(48, 384, 2, 1, 0);
    in_en = 1'b0;
    tick(); tick();
    chk("full_level", 32'(lvl_a), 4);
    chk("full_ovf", 32'(ovf_a), 0);
    chk("full_head", dat_a, 800);
    run(-49, -392, -2, 0, 0);
    in_en = 1'b0;
    tick();
    chk("ovf_early", 32'(ovf_a), 0);
    tick();
    chk("ovf_set", 32'(ovf_a), 1);
    chk("ovf_level", 32'(lvl_a), 4);
    chk("ovf_head", dat_a, 800);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr", 32'(ovf_a), 0);

    // Clear coinciding with a new overflow: set wins.
    run(-16, -128, 0, 0, 0);
    in_en = 1'b0;
    tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_set_wins", 32'(ovf_a), 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr2", 32'(ovf_a), 0);

    // Full FIFO with pop on the push edge: accepted, level stays 4.
    run(16, 128, 1, 1, 0);
    in_en = 1'b0;
    tick();
    rdy_a = 1'b1;
    tick();
    rdy_a = 1'b0;
    chk("pushpop_level", 32'(lvl_a), 4);
    chk("pushpop_ovf", 32'(ovf_a), 0);
    chk("pushpop_head", dat_a, 32760);
    drain();

    // Sync on a capture edge discards it and restarts the drop count.
    for (int i = 0; i < 15; i++) begin
      in_data = -13'sd16;
      in_en = 1'b1;
      tick();
    end
    sync = 1'b1;
    tick();
    sync = 1'b0;
    drops_left = 2;
    run(-16, -128, 0, 1, 0);
    run(-16, -128, 0, 1, 0);
    run(-16, -128, 0, 1, 0);
    in_en = 1'b0;
    tick();
    chk("sync_valid_early", 32'(vld_a), 0);
    tick();
    chk("sync_valid", 32'(vld_a), 1);
    chk("sync_data", dat_a, -128);
    tick(); tick();

    // Asynchronous reset mid-stream with three buffered samples.
    rdy_a = 1'b0;
    run(100, 800, 3, 1, 0);
    run(100, 800, 3, 1, 0);
    run(100, 800, 3, 1, 0);
    in_en = 1'b0;
    tick(); tick(); tick();
    chk("pre_rst_level", 32'(lvl_a), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(vld_a), 0);
    chk("mid_rst_level", 32'(lvl_a), 0);
    chk("mid_rst_ovf", 32'(ovf_a), 0);
    q_a.delete();
    q_b.delete();
    tick();
    rst_n = 1'b1;
    drops_left = 2;

    // Phase restarts at zero; idle in_en cycles freeze the phase.
    rdy_a = 1'b1;
    run(4095, 32760, 127, 1, 1);
    run(4095, 32760, 127, 1, 1);
    run(4095, 32760, 127, 1, 1);
    chk("restart_valid_early", 32'(vld_a), 0);
    tick();
    chk("restart_valid", 32'(vld_a), 1);
    chk("restart_data", dat_a, 32760);
    drain();
    tick(); tick();
    chk("q_a_empty", q_a.size(), 0);
    chk("q_b_empty", q_b.size(), 0);
    chk("ovf_b", 32'(ovf_b), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
